// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table scanner and its downstream consumers.
//   tt_state_e : scanner FSM states
//   row_t      : one captured truth-table row (index, observed outputs, mismatch flag)
//                sized for the default 5-in / 5-out exercise blocks
//   tt_cnt_w() : width helper for the settle counter (never zero)
package tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_PRESENT,
    ST_DONE
  } tt_state_e;

  localparam int TT_IDX_W  = 5;
  localparam int TT_DATA_W = 5;

  typedef struct packed {
    logic [TT_IDX_W-1:0]  idx;
    logic [TT_DATA_W-1:0] data;
    logic                 mis;
  } row_t;

  function automatic int tt_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tt_settle_cnt.sv
// Settle-time counter for tt_scan.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : load zero (takes priority over en)
//   en       : count up; holds once the terminal value is reached
//   hit      : counter equals SETTLE-1
module tt_settle_cnt
  import tt_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int              CW   = tt_cnt_w(SETTLE);
  localparam logic [CW-1:0]   LAST = CW'(SETTLE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !hit) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == LAST);

endmodule

// File: rtl/tt_scan.sv
// Exhaustive truth-table scanner. Drives every input combination in order,
// waits SETTLE cycles, captures the combinational block's response and hands
// each row downstream over valid/ready, counting rows where the canonical
// output (REF_BIT) and reduced output (CMP_BIT) disagree.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : scan request, sampled only in IDLE
//   in_vec       : stimulus to the block under test
//   out_vec      : response from the block under test
//   row_valid / row_ready : row handshake
//   row_idx, row_data, row_mis : presented row
//   busy         : FSM not idle
//   done         : one-cycle pulse after the last row is accepted
//   mismatch_cnt : mismatching rows in the current/last scan
module tt_scan
  import tt_pkg::*;
#(
  parameter int N_IN    = 5,
  parameter int N_OUT   = 5,
  parameter int SETTLE  = 1,
  parameter int REF_BIT = 4,
  parameter int CMP_BIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  in_vec,
  input  logic [N_OUT-1:0] out_vec,
  output logic             row_valid,
  input  logic             row_ready,
  output logic [N_IN-1:0]  row_idx,
  output logic [N_OUT-1:0] row_data,
  output logic             row_mis,
  output logic             busy,
  output logic             done,
  output logic [N_IN:0]    mismatch_cnt
);

  function automatic logic mis_of(input logic [N_OUT-1:0] v);
    return v[REF_BIT] ^ v[CMP_BIT];
  endfunction

  tt_state_e state, state_nx;
  logic      cnt_clr, cnt_en, cnt_hit;
  logic      hs, last_row, cap;

  tt_settle_cnt #(.SETTLE(SETTLE)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .hit (cnt_hit)
  );

  assign hs       = (state == ST_PRESENT) && row_valid && row_ready;
  assign last_row = &in_vec;
  assign cap      = (state == ST_SETTLE) && cnt_hit;

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_SETTLE;
          cnt_clr  = 1'b1;
        end
      end
      ST_SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_hit) state_nx = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (hs) begin
          if (last_row) begin
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_SETTLE;
            cnt_clr  = 1'b1;
          end
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Stimulus, capture and counters; in_vec only moves on the start edge or a
  // handshake edge so the block always has SETTLE full cycles before capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_vec       <= '0;
      row_valid    <= 1'b0;
      row_idx      <= '0;
      row_data     <= '0;
      done         <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      done <= (state == ST_PRESENT) && (state_nx == ST_DONE);
      if ((state == ST_IDLE) && start) begin
        in_vec       <= '0;
        mismatch_cnt <= '0;
      end
      if (cap) begin
        row_data     <= out_vec;
        row_idx      <= in_vec;
        row_valid    <= 1'b1;
        mismatch_cnt <= mismatch_cnt + {{N_IN{1'b0}}, mis_of(out_vec)};
      end
      if (hs) begin
        row_valid <= 1'b0;
        if (!last_row) in_vec <= in_vec + 1'b1;
      end
    end
  end

  assign row_mis = mis_of(row_data);
  assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_tt_scan.sv
// Self-checking bench for tt_scan: two instances (SETTLE=1 and SETTLE=3)
// driven by a random 5-in/5-out truth table, compared against an
// abstract row/timeline model.
module tb_tt_scan;

  localparam int S1   = 1;
  localparam int S3   = 3;
  localparam int NROW = 32;
  localparam int TMAX = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_drv, ready_drv, sel;

  logic start1, ready1, valid1, mis1, busy1, done1;
  logic start3, ready3, valid3, mis3, busy3, done3;
  logic [4:0] in1, out1, idx1, data1;
  logic [4:0] in3, out3, idx3, data3;
  logic [5:0] mcnt1, mcnt3;

  logic [31:0] tbl [5];

  assign out1 = {tbl[4][in1], tbl[3][in1], tbl[2][in1], tbl[1][in1], tbl[0][in1]};
  assign out3 = {tbl[4][in3], tbl[3][in3], tbl[2][in3], tbl[1][in3], tbl[0][in3]};

  assign start1 = !sel && start_drv;
  assign ready1 = !sel && ready_drv;
  assign start3 = sel && start_drv;
  assign ready3 = sel && ready_drv;

  logic       mon_valid, mon_done, mon_mis, mon_busy;
  logic [4:0] mon_idx, mon_data, mon_in;
  assign mon_valid = sel ? valid3 : valid1;
  assign mon_done  = sel ? done3  : done1;
  assign mon_mis   = sel ? mis3   : mis1;
  assign mon_busy  = sel ? busy3  : busy1;
  assign mon_idx   = sel ? idx3   : idx1;
  assign mon_data  = sel ? data3  : data1;
  assign mon_in    = sel ? in3    : in1;

  tt_scan #(.N_IN(5), .N_OUT(5), .SETTLE(S1), .REF_BIT(4), .CMP_BIT(0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_vec(in1), .out_vec(out1),
    .row_valid(valid1), .row_ready(ready1), .row_idx(idx1), .row_data(data1),
    .row_mis(mis1), .busy(busy1), .done(done1), .mismatch_cnt(mcnt1)
  );

  tt_scan #(.N_IN(5), .N_OUT(5), .SETTLE(S3), .REF_BIT(4), .CMP_BIT(0)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .in_vec(in3), .out_vec(out3),
    .row_valid(valid3), .row_ready(ready3), .row_idx(idx3), .row_data(data3),
    .row_mis(mis3), .busy(busy3), .done(done3), .mismatch_cnt(mcnt3)
  );

  int checks, errors;

  // per-cycle trace of one scan; index k = sampled after edge E0+k,
  // tr_ready[k] = ready value presented at edge E0+k+1
  logic       tr_valid [TMAX];
  logic       tr_ready [TMAX];
  logic       tr_done  [TMAX];
  logic       tr_busy  [TMAX];
  logic       tr_mis   [TMAX];
  logic [4:0] tr_idx   [TMAX];
  logic [4:0] tr_data  [TMAX];
  logic [4:0] tr_in    [TMAX];
  bit         rdy_pat  [TMAX];
  int         ncyc;
  bit         timeout;

  // ---------------- reference model ----------------
  function automatic logic [4:0] exp_data(input int i);
    logic [4:0] r;
    for (int b = 0; b < 5; b++) r[b] = tbl[b][i & 31];
    return r;
  endfunction

  function automatic logic exp_mis(input int i);
    return tbl[4][i & 31] ^ tbl[0][i & 31];
  endfunction

  function automatic int exp_count();
    int c = 0;
    for (int i = 0; i < NROW; i++) c += int'(exp_mis(i));
    return c;
  endfunction

  // kind 0: reduced form equals canonical; 1: always inverted; 2: unrelated
  task automatic new_tables(input int kind);
    for (int b = 0; b < 5; b++) tbl[b] = $urandom;
    if (kind == 0) tbl[0] = tbl[4];
    if (kind == 1) tbl[0] = ~tbl[4];
  endtask

  // mode 0: ready high; 1: ready from rdy_pat; 2: stall row 7 for 5 cycles;
  // 3: ready high plus stray start pulses on row 10 and on the done cycle
  task automatic collect(input int mode);
    int stall_left, done_k;
    bit p10;
    stall_left = 5; done_k = -1; p10 = 0; timeout = 0; ncyc = 0;
    @(negedge clk);
    start_drv = 1'b1;
    ready_drv = 1'b1;
    for (int k = 0; k < TMAX; k++) begin
      @(negedge clk);
      start_drv = 1'b0;
      case (mode)
        1: ready_drv = rdy_pat[k];
        2: begin
          ready_drv = 1'b1;
          if (mon_valid && mon_idx == 5'd7 && stall_left > 0) begin
            ready_drv = 1'b0;
            stall_left--;
          end
        end
        default: ready_drv = 1'b1;
      endcase
      if (mode == 3) begin
        if (mon_valid && mon_idx == 5'd10 && !p10) begin
          start_drv = 1'b1;
          p10 = 1'b1;
        end
        if (mon_done) start_drv = 1'b1;
      end
      tr_valid[k] = mon_valid; tr_ready[k] = ready_drv; tr_done[k] = mon_done;
      tr_busy[k]  = mon_busy;  tr_mis[k]   = mon_mis;   tr_idx[k]  = mon_idx;
      tr_data[k]  = mon_data;  tr_in[k]    = mon_in;
      ncyc = k + 1;
      if (mon_done && done_k < 0) done_k = k;
      if (done_k >= 0 && k >= done_k + 6) break;
    end
    start_drv = 1'b0;
    ready_drv = 1'b0;
    if (done_k < 0) timeout = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in1, valid1, idx1, data1, mis1, busy1, done1, mcnt1} !== 24'd0) begin
      errors++;
      $display("FAIL reset_dut1: in=%b valid=%b idx=%b data=%b busy=%b done=%b cnt=%b, need all zero",
               in1, valid1, idx1, data1, busy1, done1, mcnt1);
    end
    checks++;
    if ({in3, valid3, idx3, data3, mis3, busy3, done3, mcnt3} !== 24'd0) begin
      errors++;
      $display("FAIL reset_dut3: in=%b valid=%b idx=%b data=%b busy=%b done=%b cnt=%b, need all zero",
               in3, valid3, idx3, data3, busy3, done3, mcnt3);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_scan_basic();
    int n, first_v, ndone, done_at;
    new_tables(0);
    sel = 1'b0;
    collect(0);
    checks++;
    if (timeout) begin errors++; $display("FAIL basic_timeout: no done within %0d cycles", TMAX); end
    n = 0; first_v = -1; ndone = 0; done_at = -1;
    for (int k = 0; k < ncyc; k++) begin
      if (tr_valid[k] && first_v < 0) first_v = k;
      if (tr_done[k]) begin ndone++; if (done_at < 0) done_at = k; end
      if (tr_valid[k] && tr_ready[k]) begin
        checks++;
        if (tr_idx[k] !== 5'(n) || tr_data[k] !== exp_data(n) || tr_mis[k] !== exp_mis(n) || tr_in[k] !== 5'(n)) begin
          errors++;
          $display("FAIL basic_row %0d: idx=%0d data=%b mis=%b in=%0d, need idx=%0d data=%b mis=%b",
                   n, tr_idx[k], tr_data[k], tr_mis[k], tr_in[k], n, exp_data(n), exp_mis(n));
        end
        n++;
      end
    end
    checks++;
    if (n != NROW) begin errors++; $display("FAIL basic_rows: got %0d rows, need %0d", n, NROW); end
    checks++;
    if (first_v != S1) begin errors++; $display("FAIL basic_first_valid: at E0+%0d, need E0+%0d", first_v, S1); end
    checks++;
    if (done_at != NROW * (S1 + 1)) begin
      errors++; $display("FAIL basic_done_time: at E0+%0d, need E0+%0d", done_at, NROW * (S1 + 1));
    end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL basic_done_width: %0d cycles, need 1", ndone); end
    checks++;
    if (mcnt1 !== 6'(exp_count())) begin errors++; $display("FAIL basic_mcnt: got %0d, need %0d", mcnt1, exp_count()); end
    checks++;
    if (in1 !== 5'd31 || busy1 !== 1'b0) begin
      errors++; $display("FAIL basic_after: in=%0d busy=%b, need in=31 busy=0", in1, busy1);
    end
  endtask

  task automatic test_all_mismatch();
    int nmis, n;
    new_tables(1);
    sel = 1'b0;
    collect(0);
    checks++;
    if (timeout) begin errors++; $display("FAIL allmis_timeout: no done within %0d cycles", TMAX); end
    nmis = 0; n = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (tr_valid[k] && tr_ready[k]) begin
        if (tr_mis[k] === 1'b1 && tr_data[k] === exp_data(n)) nmis++;
        n++;
      end
    end
    checks++;
    if (nmis != NROW) begin errors++; $display("FAIL allmis_rows: %0d rows flagged with right data, need %0d", nmis, NROW); end
    checks++;
    if (mcnt1 !== 6'd32) begin errors++; $display("FAIL allmis_mcnt: got %0d, need 32", mcnt1); end
  endtask

  task automatic test_stall();
    int nstall, n, done_at;
    new_tables(2);
    sel = 1'b1;
    collect(2);
    checks++;
    if (timeout) begin errors++; $display("FAIL stall_timeout: no done within %0d cycles", TMAX); end
    nstall = 0; n = 0; done_at = -1;
    for (int k = 0; k < ncyc; k++) begin
      if (tr_done[k] && done_at < 0) done_at = k;
      if (tr_valid[k] && !tr_ready[k]) begin
        nstall++;
        checks++;
        if (tr_idx[k] !== 5'd7 || tr_data[k] !== exp_data(7) || tr_in[k] !== 5'd7) begin
          errors++;
          $display("FAIL stall_hold: idx=%0d data=%b in=%0d, need idx=7 data=%b in=7",
                   tr_idx[k], tr_data[k], tr_in[k], exp_data(7));
        end
      end
      if (tr_valid[k] && tr_ready[k]) begin
        checks++;
        if (tr_idx[k] !== 5'(n) || tr_data[k] !== exp_data(n)) begin
          errors++;
          $display("FAIL stall_row %0d: idx=%0d data=%b, need idx=%0d data=%b", n, tr_idx[k], tr_data[k], n, exp_data(n));
        end
        n++;
      end
    end
    checks++;
    if (nstall != 5) begin errors++; $display("FAIL stall_cycles: %0d, need 5", nstall); end
    checks++;
    if (done_at != NROW * (S3 + 1) + 5) begin
      errors++; $display("FAIL stall_done_time: at E0+%0d, need E0+%0d", done_at, NROW * (S3 + 1) + 5);
    end
    checks++;
    if (mcnt3 !== 6'(exp_count())) begin errors++; $display("FAIL stall_mcnt: got %0d, need %0d", mcnt3, exp_count()); end
  endtask

  task automatic test_random_ready();
    int hs_at [NROW];
    bit exp_v [TMAX];
    int t, tp, n, exp_done, done_at, vbad;
    new_tables(2);
    sel = 1'b1;
    for (int k = 0; k < TMAX; k++) rdy_pat[k] = (k >= 300) ? 1'b1 : 1'($urandom_range(0, 1));
    for (int k = 0; k < TMAX; k++) exp_v[k] = 1'b0;
    // each row: valid SETTLE cycles after the previous handshake, held until ready
    t = S3;
    for (int r = 0; r < NROW; r++) begin
      tp = t;
      while (!rdy_pat[tp]) tp++;
      for (int j = t; j <= tp; j++) exp_v[j] = 1'b1;
      hs_at[r] = tp;
      t = tp + 1 + S3;
    end
    exp_done = hs_at[NROW-1] + 1;
    collect(1);
    checks++;
    if (timeout) begin errors++; $display("FAIL rand_timeout: no done within %0d cycles", TMAX); end
    n = 0; done_at = -1; vbad = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (tr_done[k] && done_at < 0) done_at = k;
      if (tr_valid[k] !== exp_v[k]) vbad++;
      if (tr_valid[k] && tr_ready[k]) begin
        checks++;
        if (n >= NROW || k != hs_at[n & 31] || tr_idx[k] !== 5'(n) || tr_data[k] !== exp_data(n) || tr_mis[k] !== exp_mis(n)) begin
          errors++;
          $display("FAIL rand_row %0d: cycle=%0d idx=%0d data=%b mis=%b, need cycle=%0d idx=%0d data=%b mis=%b",
                   n, k, tr_idx[k], tr_data[k], tr_mis[k], hs_at[n & 31], n, exp_data(n), exp_mis(n));
        end
        n++;
      end
    end
    checks++;
    if (vbad != 0) begin errors++; $display("FAIL rand_valid_trace: %0d cycles differ, need 0", vbad); end
    checks++;
    if (n != NROW) begin errors++; $display("FAIL rand_rows: got %0d rows, need %0d", n, NROW); end
    checks++;
    if (done_at != exp_done) begin errors++; $display("FAIL rand_done_time: at E0+%0d, need E0+%0d", done_at, exp_done); end
    checks++;
    if (mcnt3 !== 6'(exp_count())) begin errors++; $display("FAIL rand_mcnt: got %0d, need %0d", mcnt3, exp_count()); end
  endtask

  task automatic test_start_ignored();
    int n, ndone, done_at, bad_busy;
    new_tables(2);
    sel = 1'b0;
    collect(3);
    checks++;
    if (timeout) begin errors++; $display("FAIL ign_timeout: no done within %0d cycles", TMAX); end
    n = 0; ndone = 0; done_at = -1; bad_busy = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (tr_done[k]) begin ndone++; if (done_at < 0) done_at = k; end
      if (done_at >= 0 && k > done_at && tr_busy[k] !== 1'b0) bad_busy++;
      if (tr_valid[k] && tr_ready[k]) begin
        if (tr_idx[k] === 5'(n)) n++;
        else n += 100;
      end
    end
    checks++;
    if (n != NROW) begin errors++; $display("FAIL ign_rows: order score %0d, need %0d", n, NROW); end
    checks++;
    if (ndone != 1 || done_at != NROW * (S1 + 1)) begin
      errors++; $display("FAIL ign_done: %0d pulses at E0+%0d, need 1 at E0+%0d", ndone, done_at, NROW * (S1 + 1));
    end
    checks++;
    if (bad_busy != 0) begin errors++; $display("FAIL ign_restart: busy in %0d cycles after done, need 0", bad_busy); end
    checks++;
    if (mcnt1 !== 6'(exp_count())) begin errors++; $display("FAIL ign_mcnt: got %0d, need %0d", mcnt1, exp_count()); end
  endtask

  task automatic test_reset_mid();
    bit found;
    int n, first_idx;
    new_tables(1);
    sel = 1'b0;
    @(negedge clk);
    start_drv = 1'b1;
    ready_drv = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      start_drv = 1'b0;
      if (valid1 && idx1 == 5'd20) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midrst_reach: row 20 not seen, need it within 200 cycles"); end
    rst = 1'b1;
    #1;
    checks++;
    if ({in1, valid1, idx1, data1, mis1, busy1, done1, mcnt1} !== 24'd0) begin
      errors++;
      $display("FAIL midrst_async: in=%b valid=%b idx=%b data=%b busy=%b done=%b cnt=%b, need all zero",
               in1, valid1, idx1, data1, busy1, done1, mcnt1);
    end
    ready_drv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    new_tables(2);
    collect(0);
    checks++;
    if (timeout) begin errors++; $display("FAIL midrst_timeout: no done within %0d cycles", TMAX); end
    n = 0; first_idx = -1;
    for (int k = 0; k < ncyc; k++) begin
      if (tr_valid[k] && tr_ready[k]) begin
        if (first_idx < 0) first_idx = int'(tr_idx[k]);
        n++;
      end
    end
    checks++;
    if (first_idx != 0 || n != NROW) begin
      errors++; $display("FAIL midrst_rescan: first idx %0d rows %0d, need 0 and %0d", first_idx, n, NROW);
    end
    checks++;
    if (mcnt1 !== 6'(exp_count())) begin errors++; $display("FAIL midrst_mcnt: got %0d, need %0d", mcnt1, exp_count()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start_drv = 1'b0;
    ready_drv = 1'b0;
    sel = 1'b0;
    for (int b = 0; b < 5; b++) tbl[b] = 32'd0;
    test_reset();
    test_scan_basic();
    test_all_mismatch();
    test_stall();
    test_random_ready();
    test_start_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
